// File: rtl/ccd_capture_pkg.sv
// Shared types and default sizing for the CCD capture front end.
// Contents:
//   state_t          capture control states
//   DEF_*            default parameter values used by the interface and modules
package ccd_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE
  } state_t;

  localparam int DEF_COLUMN_WIDTH = 1280;
  localparam int DEF_DATA_W       = 12;
  localparam int DEF_CNT_W        = 11;
  localparam int DEF_FRAME_W      = 32;

endpackage

// File: rtl/ccd_capture_sync_if.sv
// Sensor-side and pixel-stream-side signals of the CCD capture block.
// Signals:
//   iDATA, iFVAL, iLVAL   raw Bayer pixel, frame valid, line valid from the sensor
//   iSTART, iEND          single-cycle capture arm / stop-at-end-of-frame pulses
//   oDATA, oDVAL          qualified pixel and its valid
//   oX_Cont, oY_Cont      column/row of the pixel on oDATA
//   oFrame_Cont           completed frames since reset
//   oLINE_ERR             sticky short-line flag
// Modports: slave = capture block, master = sensor/controller/consumer side.
interface ccd_capture_sync_if
  import ccd_capture_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int FRAME_W = DEF_FRAME_W
) ();

  logic [DATA_W-1:0]  iDATA;
  logic               iFVAL;
  logic               iLVAL;
  logic               iSTART;
  logic               iEND;
  logic [DATA_W-1:0]  oDATA;
  logic               oDVAL;
  logic [CNT_W-1:0]   oX_Cont;
  logic [CNT_W-1:0]   oY_Cont;
  logic [FRAME_W-1:0] oFrame_Cont;
  logic               oLINE_ERR;

  modport master (
    output iDATA, iFVAL, iLVAL, iSTART, iEND,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oLINE_ERR
  );

  modport slave (
    input  iDATA, iFVAL, iLVAL, iSTART, iEND,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oLINE_ERR
  );

endinterface

// File: rtl/ccd_xy_counter.sv
// Pixel coordinate tracker for the capture block.
// Keeps the coordinate of the next pixel internally and publishes the
// coordinate of each emitted pixel on the same edge the pixel is emitted.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   pix          a valid pixel is being emitted this edge
//   line_end     line valid fell (line finished)
//   clear        frame boundary: coordinates return to 0 (highest priority)
//   x, y         coordinate of the pixel currently on the output
//   line_err     sticky: a line ended before COLUMN_WIDTH pixels
module ccd_xy_counter
  import ccd_capture_pkg::*;
#(
  parameter int COLUMN_WIDTH = DEF_COLUMN_WIDTH,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix,
  input  logic             line_end,
  input  logic             clear,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_err
);

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLUMN_WIDTH - 1);

  logic [CNT_W-1:0] nx;
  logic [CNT_W-1:0] ny;

  // Row index sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nx       <= '0;
      ny       <= '0;
      x        <= '0;
      y        <= '0;
      line_err <= 1'b0;
    end else if (clear) begin
      nx <= '0;
      ny <= '0;
      x  <= '0;
      y  <= '0;
    end else if (pix) begin
      x <= nx;
      y <= ny;
      if (nx == LAST_COL) begin
        nx <= '0;
        ny <= sat_inc(ny);
      end else begin
        nx <= nx + CNT_W'(1);
      end
    end else if (line_end && (nx != '0)) begin
      // A line that wrapped exactly already advanced the row; only a short
      // line needs the extra step and the error flag.
      nx       <= '0;
      ny       <= sat_inc(ny);
      line_err <= 1'b1;
    end
  end

endmodule

// File: rtl/ccd_capture_sync.sv
// CCD capture synchroniser: turns raw sensor strobes into a qualified pixel
// stream with coordinates and a frame count. Capture is armed and stopped
// only on frame boundaries so downstream never sees a partial frame.
// Pixel latency is two cycles (input register + output register).
// Ports:
//   iCLK   pixel clock
//   iRST   synchronous reset, active-low
//   bus    ccd_capture_sync_if.slave (sensor inputs, start/end, pixel outputs)
module ccd_capture_sync
  import ccd_capture_pkg::*;
#(
  parameter int COLUMN_WIDTH = DEF_COLUMN_WIDTH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FRAME_W      = DEF_FRAME_W
) (
  input  logic                iCLK,
  input  logic                iRST,
  ccd_capture_sync_if.slave   bus
);

  state_t              state;
  state_t              state_nxt;
  logic                stop_pending;
  logic [DATA_W-1:0]   data_p0;
  logic                fval_p0;
  logic                lval_p0;
  logic                fval_p1;
  logic                lval_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                vld_p1;
  logic [FRAME_W-1:0]  frame_cnt;
  logic                fval_rise;
  logic                fval_fall;
  logic                lval_fall;
  logic                pix;
  logic                line_end;
  logic                clear;
  logic                frame_done;
  logic                stop_set;
  logic [CNT_W-1:0]    x;
  logic [CNT_W-1:0]    y;
  logic                line_err;

  assign fval_rise = fval_p0 & ~fval_p1;
  assign fval_fall = ~fval_p0 & fval_p1;
  assign lval_fall = ~lval_p0 & lval_p1;

  always_ff @(posedge iCLK) begin
    if (!iRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pix        = 1'b0;
    line_end   = 1'b0;
    clear      = 1'b0;
    frame_done = 1'b0;
    stop_set   = 1'b0;
    case (state)
      IDLE: begin
        // A stop request in the same cycle overrides the start.
        if (bus.iSTART && !bus.iEND) state_nxt = ARMED;
      end
      ARMED: begin
        if (bus.iEND) begin
          state_nxt = IDLE;
        end else if (fval_rise) begin
          state_nxt = ACTIVE;
          clear     = 1'b1;
        end
      end
      ACTIVE: begin
        // Frame end wins over a coincident line end so the row is not
        // bumped just before being cleared.
        if (fval_fall) begin
          frame_done = 1'b1;
          clear      = 1'b1;
          if (stop_pending || bus.iEND) state_nxt = IDLE;
        end else begin
          pix      = fval_p0 & lval_p0;
          line_end = lval_fall;
          stop_set = bus.iEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      stop_pending <= 1'b0;
      data_p0      <= '0;
      fval_p0      <= 1'b0;
      lval_p0      <= 1'b0;
      fval_p1      <= 1'b0;
      lval_p1      <= 1'b0;
      data_p1      <= '0;
      vld_p1       <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      // Stage p0: sensor input register, plus previous strobes for edges
      data_p0 <= bus.iDATA;
      fval_p0 <= bus.iFVAL;
      lval_p0 <= bus.iLVAL;
      fval_p1 <= fval_p0;
      lval_p1 <= lval_p0;
      // Stage p1: qualified output register
      data_p1 <= data_p0;
      vld_p1  <= pix;
      if (frame_done) frame_cnt <= frame_cnt + FRAME_W'(1);
      if (frame_done)    stop_pending <= 1'b0;
      else if (stop_set) stop_pending <= 1'b1;
    end
  end

  ccd_xy_counter #(
    .COLUMN_WIDTH (COLUMN_WIDTH),
    .CNT_W        (CNT_W)
  ) u_xy (
    .clk      (iCLK),
    .rst_n    (iRST),
    .pix      (pix),
    .line_end (line_end),
    .clear    (clear),
    .x        (x),
    .y        (y),
    .line_err (line_err)
  );

  assign bus.oDATA       = data_p1;
  assign bus.oDVAL       = vld_p1;
  assign bus.oX_Cont     = x;
  assign bus.oY_Cont     = y;
  assign bus.oFrame_Cont = frame_cnt;
  assign bus.oLINE_ERR   = line_err;

endmodule

// File: tb/tb_ccd_capture_sync.sv
// Testbench for ccd_capture_sync: randomized pixel data and blanking,
// directed capture-control scenarios, frame-level reference model.
module tb_ccd_capture_sync;
  import ccd_capture_pkg::*;

  localparam int CW   = DEF_COLUMN_WIDTH;
  localparam int DW   = DEF_DATA_W;
  localparam int CNTW = DEF_CNT_W;
  localparam int FW   = DEF_FRAME_W;
  localparam int YMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ccd_capture_sync_if #(.DATA_W(DW), .CNT_W(CNTW), .FRAME_W(FW)) bus ();

  ccd_capture_sync #(
    .COLUMN_WIDTH (CW),
    .DATA_W       (DW),
    .CNT_W        (CNTW),
    .FRAME_W      (FW)
  ) dut (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            x;
    int            y;
    int            due;
  } pix_t;

  pix_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   zero_chk = 1'b0;

  // Frame-level model of the capture control and coordinates
  bit   m_run, m_stop, frame_cap;
  int   m_frames, m_x, m_y;
  bit   m_lerr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic exp_v;
    exp_v = 1'b0;
    if (q.size() > 0) begin
      if (q[0].due == cyc) exp_v = 1'b1;
    end
    chk("dval", 64'(bus.oDVAL), 64'(exp_v));
    if (exp_v) begin
      if (bus.oDVAL === 1'b1) begin
        chk("data", 64'(bus.oDATA), 64'(q[0].data));
        chk("x", 64'(bus.oX_Cont), 64'(q[0].x));
        chk("y", 64'(bus.oY_Cont), 64'(q[0].y));
      end
      void'(q.pop_front());
    end
    if (zero_chk) begin
      chk("rst_data", 64'(bus.oDATA), 64'd0);
      chk("rst_x", 64'(bus.oX_Cont), 64'd0);
      chk("rst_y", 64'(bus.oY_Cont), 64'd0);
      chk("rst_frame", 64'(bus.oFrame_Cont), 64'd0);
      chk("rst_lerr", 64'(bus.oLINE_ERR), 64'd0);
      zero_chk = 1'b0;
    end
  endtask

  // One pixel clock: check outputs, then return pulses to their idle level.
  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    bus.iSTART = 1'b0;
    bus.iEND   = 1'b0;
    rst_n      = 1'b1;
  endtask

  task automatic start_pulse();
    tick();
    bus.iSTART = 1'b1;
    m_run = 1'b1;
  endtask

  task automatic next_row();
    m_y = (m_y == YMAX) ? m_y : m_y + 1;
  endtask

  task automatic apply_event(input int kind);
    case (kind)
      1: begin
        bus.iEND = 1'b1;
        if (frame_cap) m_stop = 1'b1;
        else           m_run  = 1'b0;
      end
      2: begin
        bus.iSTART = 1'b1;
        m_run = 1'b1;
      end
      3: begin
        rst_n = 1'b0;
        q.delete();
        frame_cap = 1'b0;
        m_run = 1'b0; m_stop = 1'b0; m_frames = 0;
        m_lerr = 1'b0; m_x = 0; m_y = 0;
        zero_chk = 1'b1;
      end
      default: ;
    endcase
  endtask

  // ev_kind: 0 none, 1 iEND, 2 iSTART, 3 reset pulse, at frame pixel ev_pix
  task automatic send_frame(input int nlines, input int short_line, input int short_len,
                            input bit coincide, input int ev_pix, input int ev_kind);
    int  pcount;
    int  len;
    bit  last_co;
    pcount = 0;
    tick();
    bus.iFVAL = 1'b1;
    bus.iLVAL = 1'b0;
    frame_cap = m_run;
    m_x = 0;
    m_y = 0;
    repeat ($urandom_range(2, 5)) tick();
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? short_len : CW;
      for (int i = 0; i < len; i++) begin
        tick();
        bus.iLVAL = 1'b1;
        bus.iDATA = DW'($urandom);
        if (pcount == ev_pix) apply_event(ev_kind);
        if (frame_cap) begin
          q.push_back(pix_t'{bus.iDATA, m_x, m_y, cyc + 2});
          if (m_x == CW - 1) begin
            m_x = 0;
            next_row();
          end else begin
            m_x++;
          end
        end
        pcount++;
      end
      tick();
      bus.iLVAL = 1'b0;
      last_co = coincide && (l == nlines - 1);
      if (last_co) begin
        bus.iFVAL = 1'b0;
      end else begin
        if (frame_cap && m_x != 0) begin
          m_x = 0;
          next_row();
          m_lerr = 1'b1;
        end
        repeat ($urandom_range(2, 6)) tick();
      end
    end
    if (!coincide) begin
      tick();
      bus.iFVAL = 1'b0;
    end
    if (frame_cap) begin
      m_frames++;
      m_x = 0;
      m_y = 0;
      if (m_stop) begin
        m_run  = 1'b0;
        m_stop = 1'b0;
      end
    end
    repeat (4) tick();
    chk("frame_cnt", 64'(bus.oFrame_Cont), 64'(m_frames));
    chk("x_end", 64'(bus.oX_Cont), 64'(m_x));
    chk("y_end", 64'(bus.oY_Cont), 64'(m_y));
    chk("line_err", 64'(bus.oLINE_ERR), 64'(m_lerr));
  endtask

  initial begin
    bus.iDATA  = '0;
    bus.iFVAL  = 1'b0;
    bus.iLVAL  = 1'b0;
    bus.iSTART = 1'b0;
    bus.iEND   = 1'b0;
    rst_n      = 1'b0;
    m_run = 1'b0; m_stop = 1'b0; frame_cap = 1'b0;
    m_frames = 0; m_x = 0; m_y = 0; m_lerr = 1'b0;

    // Reset state
    repeat (3) begin
      tick();
      rst_n = 1'b0;
    end
    zero_chk = 1'b1;
    tick();

    // Two full lines captured after a start
    start_pulse();
    send_frame(2, -1, 0, 1'b0, -1, 0);

    // Short first line, last line ends together with the frame
    send_frame(3, 0, 1000, 1'b1, -1, 0);

    // Stop requested mid-frame: this frame completes, the next is ignored
    send_frame(2, -1, 0, 1'b0, 700, 1);
    send_frame(2, -1, 0, 1'b1, -1, 0);

    // Start while a frame is already running: wait for the next frame
    send_frame(1, -1, 0, 1'b0, 100, 2);
    send_frame(2, -1, 0, 1'b0, 300, 1);

    // Start and end together from idle
    tick();
    bus.iSTART = 1'b1;
    bus.iEND   = 1'b1;
    send_frame(1, -1, 0, 1'b0, -1, 0);

    // Reset pulse at pixel 500 of the first line
    start_pulse();
    send_frame(2, -1, 0, 1'b0, 500, 3);

    // Capture again after a fresh start
    start_pulse();
    send_frame(2, -1, 0, 1'b0, -1, 0);

    chk("pending_pixels", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccd_capture_sync.md
Name: ccd_capture_sync

Overview:
- Upstream neighbour of the image-processing stage.
- Converts raw camera strobes (frame valid, line valid, 12-bit Bayer data) into a qualified pixel stream with pixel-aligned column/row coordinates and a running frame count.
- Its outputs drive the processing stage's pixel data, data-valid, X and Y inputs directly.
- Start/stop control arms capture only at frame boundaries, so downstream never sees a partial frame.

Parameters:
COLUMN_WIDTH, 1280, active pixels per line; X wraps to 0 after COLUMN_WIDTH-1
DATA_W, 12, pixel data width
CNT_W, 11, X/Y coordinate width
FRAME_W, 32, frame counter width

Ports:
iCLK  in  1  pixel clock; all logic on rising edge
iRST  in  1  synchronous reset, active-low
iDATA  in  DATA_W  raw Bayer pixel from sensor
iFVAL  in  1  sensor frame valid
iLVAL  in  1  sensor line valid
iSTART  in  1  single-cycle pulse; arm capture
iEND  in  1  single-cycle pulse; stop capture at end of current frame
oDATA  out  DATA_W  registered pixel
oDVAL  out  1  pixel valid, aligned with oDATA
oX_Cont  out  CNT_W  column index of pixel on oDATA
oY_Cont  out  CNT_W  row index of pixel on oDATA
oFrame_Cont  out  FRAME_W  completed frames since reset
oLINE_ERR  out  1  sticky: a line ended short of COLUMN_WIDTH pixels

Behaviour:
Reset:
- iRST=0 sampled on a rising edge forces all outputs to 0, state IDLE, stop_pending=0, input registers to 0.
- Applies mid-frame too: capture resumes only after a new iSTART and a new FVAL rising edge.

Input stage:
- iDATA/iFVAL/iLVAL registered every cycle (rDATA, rFVAL, rLVAL).
- Previous rFVAL/rLVAL kept for edge detection.

Latency:
- Fixed 2 cycles from iDATA to oDATA: input register + output register.
- oX_Cont/oY_Cont are the coordinates of the pixel currently on oDATA, updated on the same edge.

FSM:
- IDLE:
  - iSTART=1 -> ARMED.
  - oDVAL held 0; counters held.
- ARMED:
  - Wait for rFVAL rising edge (prev 0, now 1), then -> ACTIVE with X=0, Y=0.
  - If FVAL is already high when armed, the remainder of that frame is ignored.
  - iEND -> IDLE.
- ACTIVE:
  - oDVAL <= rFVAL & rLVAL; oDATA <= rDATA every cycle (don't-care when oDVAL=0).
  - iEND sets stop_pending.
  - On rFVAL falling edge:
    - oFrame_Cont +1 (wraps mod 2^FRAME_W).
    - X, Y <= 0.
    - -> IDLE if stop_pending (then clear it), else -> ARMED-equivalent wait for the next rising edge, staying in ACTIVE with oDVAL=0.

Coordinate rules:
- Each emitted valid pixel advances X after output.
- After X=COLUMN_WIDTH-1: X <= 0, Y <= Y+1.
- rLVAL falling edge with X!=0 (short line): X <= 0, Y <= Y+1, oLINE_ERR <= 1 (cleared only by reset).
- rLVAL falling with X=0 (line ended exactly on wrap): no extra Y increment.
- Y saturates at 2^CNT_W-1; no wrap.

Simultaneous events:
- iSTART and iEND in the same cycle: iEND wins; IDLE stays IDLE.
- iSTART while ARMED/ACTIVE: ignored.
- FVAL fall coinciding with the last pixel's LVAL fall: frame-end rules take priority; Y is not incremented before the clear.

Decomposition:
- Package ccd_capture_pkg:
  - state enum {IDLE, ARMED, ACTIVE}
  - default constants COLUMN_WIDTH=1280, DATA_W=12, CNT_W=11, FRAME_W=32
- One natural sub-module: ccd_xy_counter.
  - Inputs: pixel-valid strobe, line-end strobe, frame-clear.
  - Outputs: X/Y with wrap, saturation and short-line flag.
- FSM, edge detection and data registers stay in the top.

Test Plan:
- Reset then iSTART; FVAL rises, 2 lines of 1280 LVAL-high pixels with data = running count -> oDVAL high 2560 cycles, oDATA equals input 2 cycles delayed, X runs 0..1279 twice, Y=0 then 1; FVAL fall -> oFrame_Cont=1, X=Y=0.
- iSTART mid-frame (FVAL already high) -> oDVAL stays 0 until the next FVAL rise; first captured pixel has X=0, Y=0.
- iEND during a frame -> current frame completes, oFrame_Cont increments once; the following frame gives oDVAL=0 throughout.
- Line of 1000 pixels then LVAL fall -> X returns 0, Y increments, oLINE_ERR=1 and remains 1 through later good lines.
- iSTART and iEND in the same cycle from IDLE -> stays IDLE, no oDVAL over a full frame.
- iRST=0 for one cycle at pixel 500 of a line -> next edge all outputs 0; no oDVAL until a new iSTART plus FVAL rise; oFrame_Cont=0.
